// File: rtl/xadac_pkg.sv
// Shared types and constants for the xadac vector decode slice.
package xadac_pkg;

    localparam int IdW  = 4;
    localparam int NoVs = 3;

    typedef logic [IdW-1:0] IdT;

    // Major opcode (custom-0) that the decode stage claims by default
    localparam logic [6:0] OpcodeDefault = 7'h0B;

    typedef enum logic [2:0] {
        VADD   = 3'b000,
        VMAC   = 3'b001,
        VLOAD  = 3'b010,
        VSTORE = 3'b011
    } vop_e;

    typedef struct packed {
        IdT              id;
        logic            accept;
        logic            vd_clobber;
        logic [NoVs-1:0] vs_read;
    } dec_rsp_t;

endpackage

// File: rtl/xadac_fifo.sv
// In-order response buffer: Depth entries of dec_rsp_t with count/full/empty.
module xadac_fifo
    import xadac_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  dec_rsp_t                 data_i,
    input  logic                     pop_i,
    output dec_rsp_t                 data_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    dec_rsp_t          mem_q [Depth];
    logic [PtrW-1:0]   wr_q, wr_d;
    logic [PtrW-1:0]   rd_q, rd_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              doPush;
    logic              doPop;

    // Guard the handshakes so an overflow or underflow can never corrupt the pointers
    always_comb begin
        doPush = push_i && !full_o;
        doPop  = pop_i && !empty_o;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        if (doPush) begin
            wr_d = wr_q + 1'b1;
        end
        if (doPop) begin
            rd_d = rd_q + 1'b1;
        end
        if (doPush && !doPop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (doPop && !doPush) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointer, count and storage registers; storage cleared so outputs read zero after reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (doPush) begin
                mem_q[wr_q] <= data_i;
            end
        end
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/xadac_vdecode.sv
// Decode stage of the xadac vector coprocessor: decodes requests and returns buffered,
// in-order responses carrying accept / vd_clobber / vs_read for the hazard scoreboard.
module xadac_vdecode
    import xadac_pkg::*;
#(
    parameter int         Depth  = 2,
    parameter logic [6:0] Opcode = OpcodeDefault
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  IdT               req_id,
    input  logic [31:0]      req_instr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output IdT               rsp_id,
    output logic             rsp_accept,
    output logic             rsp_vd_clobber,
    output logic [NoVs-1:0]  rsp_vs_read,
    output logic [15:0]      rej_count
);

    // Rejected instructions always produce an all-zero result, never a partial mask
    function automatic dec_rsp_t decode(input logic [31:0] instr, input IdT id);
        dec_rsp_t r;
        r    = '0;
        r.id = id;
        if (instr[1:0] == 2'b11 && instr[6:0] == Opcode) begin
            case (instr[14:12])
                VADD: begin
                    r.accept     = 1'b1;
                    r.vd_clobber = 1'b1;
                    r.vs_read    = 3'b011;
                end
                VMAC: begin
                    r.accept     = 1'b1;
                    r.vd_clobber = 1'b1;
                    r.vs_read    = 3'b111;
                end
                VLOAD: begin
                    r.accept     = 1'b1;
                    r.vd_clobber = 1'b1;
                    r.vs_read    = 3'b000;
                end
                VSTORE: begin
                    r.accept     = 1'b1;
                    r.vd_clobber = 1'b0;
                    r.vs_read    = 3'b100;
                end
                default: begin
                    r.accept     = 1'b0;
                    r.vd_clobber = 1'b0;
                    r.vs_read    = '0;
                end
            endcase
        end
        return r;
    endfunction

    dec_rsp_t               decoded;
    dec_rsp_t               head;
    logic [$clog2(Depth):0] fifoCount;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic                   reqFire;
    logic                   rspFire;
    logic [15:0]            rej_q, rej_d;
    logic                   unused_instr_bits;

    // Register-number fields are forwarded by position only, so the decoder ignores them
    assign unused_instr_bits = ^{req_instr[31:15], req_instr[11:7], fifoCount};

    assign decoded   = decode(req_instr, req_id);
    assign req_ready = !fifoFull;
    assign reqFire   = req_valid && req_ready;
    assign rsp_valid = !fifoEmpty;
    assign rspFire   = rsp_valid && rsp_ready;

    xadac_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (reqFire),
        .data_i  (decoded),
        .pop_i   (rspFire),
        .data_o  (head),
        .count_o (fifoCount),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Saturating reject counter advances only for requests actually taken
    always_comb begin
        rej_d = rej_q;
        if (reqFire && !decoded.accept && rej_q != 16'hFFFF) begin
            rej_d = rej_q + 16'd1;
        end
    end

    // Reject counter register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rej_q <= '0;
        end else begin
            rej_q <= rej_d;
        end
    end

    assign rsp_id         = head.id;
    assign rsp_accept     = head.accept;
    assign rsp_vd_clobber = head.vd_clobber;
    assign rsp_vs_read    = head.vs_read;
    assign rej_count      = rej_q;

endmodule

// File: tb/tb_xadac_vdecode.sv
// Directed bench for xadac_vdecode: inputs change and outputs are sampled on the falling edge.
module tb_xadac_vdecode;
    import xadac_pkg::*;

    logic             clk;
    logic             rstn;
    logic             req_valid;
    logic             req_ready;
    IdT               req_id;
    logic [31:0]      req_instr;
    logic             rsp_valid;
    logic             rsp_ready;
    IdT               rsp_id;
    logic             rsp_accept;
    logic             rsp_vd_clobber;
    logic [NoVs-1:0]  rsp_vs_read;
    logic [15:0]      rej_count;

    int checks;
    int failures;

    xadac_vdecode #(
        .Depth  (2),
        .Opcode (7'h0B)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_id         (req_id),
        .req_instr      (req_instr),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_accept     (rsp_accept),
        .rsp_vd_clobber (rsp_vd_clobber),
        .rsp_vs_read    (rsp_vs_read),
        .rej_count      (rej_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mkInstr(input logic [6:0] op, input logic [2:0] f3);
        return {7'd0, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    task automatic applyStimulus(input logic v, input logic [3:0] id, input logic [31:0] instr);
        req_valid = v;
        req_id    = id;
        req_instr = instr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkRsp(input string tag, input logic [3:0] id, input logic acc,
                            input logic vd, input logic [2:0] vs);
        checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        checkOutput({tag, "_id"}, 32'(rsp_id), 32'(id));
        checkOutput({tag, "_accept"}, 32'(rsp_accept), 32'(acc));
        checkOutput({tag, "_vd"}, 32'(rsp_vd_clobber), 32'(vd));
        checkOutput({tag, "_vs"}, 32'(rsp_vs_read), 32'(vs));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rstn      = 1'b0;
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'd0);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_rej_count", 32'(rej_count), 32'd0);
        checkOutput("rst_rsp_data", {rsp_id, rsp_accept, rsp_vd_clobber, rsp_vs_read}, 32'd0);
        rstn = 1'b1;

        // 1: VADD id=3, response one cycle after the handshake
        @(negedge clk);
        rsp_ready = 1'b1;
        applyStimulus(1'b1, 4'd3, mkInstr(7'h0B, 3'b000));
        #1;
        checkOutput("t1_no_bypass", 32'(rsp_valid), 32'd0);
        checkOutput("t1_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        checkRsp("t1", 4'd3, 1'b1, 1'b1, 3'b011);
        applyStimulus(1'b0, 4'd0, 32'd0);

        // 2: foreign opcode is rejected and counted
        @(negedge clk);
        checkOutput("t2_drained", 32'(rsp_valid), 32'd0);
        applyStimulus(1'b1, 4'd1, mkInstr(7'h33, 3'b000));
        @(negedge clk);
        checkRsp("t2", 4'd1, 1'b0, 1'b0, 3'b000);
        checkOutput("t2_rej_count", 32'(rej_count), 32'd1);
        applyStimulus(1'b0, 4'd0, 32'd0);

        // 3: fill with rsp_ready low, then release
        @(negedge clk);
        rsp_ready = 1'b0;
        applyStimulus(1'b1, 4'd0, mkInstr(7'h0B, 3'b001));
        @(negedge clk);
        checkRsp("t3_head0", 4'd0, 1'b1, 1'b1, 3'b111);
        applyStimulus(1'b1, 4'd1, mkInstr(7'h0B, 3'b011));
        @(negedge clk);
        checkOutput("t3_full_ready", 32'(req_ready), 32'd0);
        checkRsp("t3_stable", 4'd0, 1'b1, 1'b1, 3'b111);
        applyStimulus(1'b1, 4'd2, mkInstr(7'h0B, 3'b000));
        rsp_ready = 1'b1;
        #1;
        checkOutput("t3_full_pop_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        checkRsp("t3_second", 4'd1, 1'b1, 1'b0, 3'b100);
        checkOutput("t3_ready_back", 32'(req_ready), 32'd1);
        applyStimulus(1'b0, 4'd0, 32'd0);
        @(negedge clk);
        checkOutput("t3_no_extra", 32'(rsp_valid), 32'd0);

        // 4: back-to-back streaming, one response per cycle in order
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 4'(i + 4), mkInstr(7'h0B, 3'b010));
            @(negedge clk);
            checkRsp("t4_stream", 4'(i + 4), 1'b1, 1'b1, 3'b000);
            checkOutput("t4_ready", 32'(req_ready), 32'd1);
        end
        applyStimulus(1'b0, 4'd0, 32'd0);
        @(negedge clk);
        checkOutput("t4_drained", 32'(rsp_valid), 32'd0);

        // 5: funct3=101 with our opcode is rejected; counter saturates
        applyStimulus(1'b1, 4'd5, mkInstr(7'h0B, 3'b101));
        @(negedge clk);
        checkRsp("t5_f3_101", 4'd5, 1'b0, 1'b0, 3'b000);
        checkOutput("t5_rej_2", 32'(rej_count), 32'd2);
        repeat (65532) @(negedge clk);
        checkOutput("t5_rej_fffe", 32'(rej_count), 32'hFFFE);
        @(negedge clk);
        checkOutput("t5_rej_ffff", 32'(rej_count), 32'hFFFF);
        repeat (4465) @(negedge clk);
        checkOutput("t5_rej_sat", 32'(rej_count), 32'hFFFF);
        applyStimulus(1'b0, 4'd0, 32'd0);
        @(negedge clk);

        // 6: reset with two buffered responses discards them
        rsp_ready = 1'b0;
        applyStimulus(1'b1, 4'd7, mkInstr(7'h0B, 3'b000));
        @(negedge clk);
        applyStimulus(1'b1, 4'd8, mkInstr(7'h0B, 3'b001));
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 32'd0);
        checkOutput("t6_full", 32'(req_ready), 32'd0);
        checkRsp("t6_head", 4'd7, 1'b1, 1'b1, 3'b011);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("t6_rst_ready", 32'(req_ready), 32'd1);
        checkOutput("t6_rst_rej", 32'(rej_count), 32'd0);
        @(negedge clk);
        rstn      = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t6_no_stale", 32'(rsp_valid), 32'd0);
        end
        applyStimulus(1'b1, 4'd9, mkInstr(7'h0B, 3'b010));
        @(negedge clk);
        checkRsp("t6_fresh", 4'd9, 1'b1, 1'b1, 3'b000);
        applyStimulus(1'b0, 4'd0, 32'd0);
        @(negedge clk);
        checkOutput("t6_fresh_only", 32'(rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
